d_hazard_scoreboard: RTL and testbench
======================================

D_HAZARD_SCOREBOARD -- requirements
Module: d_hazard_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter LOAD_LAT, default 2, legal 1..7: cycles from load issue to load data on resultW.
REQ-003 SHALL have ports clk (in, 1, clock, rising edge) and rst_n (in, 1, asynchronous active-low reset).
REQ-004 SHALL have inputs issue (1, D instruction advances to E this cycle) and flush (1, squash D instruction).
REQ-005 SHALL have inputs rs1D, rs2D, rdD (5 each) and reg_writeD, is_loadD (1 each): D-stage decode fields.
REQ-006 SHALL have inputs jump_code (2): 00 none, 01 branch, 11 jalr.
REQ-007 SHALL have inputs source1D, source2D (XLEN): register file read data.
REQ-008 SHALL have inputs aluE (XLEN): combinational ALU result of the instruction held in E.
REQ-009 SHALL have inputs wb_valid (1), rdW (5), resultW (XLEN): load data return.
REQ-010 SHALL have outputs reg_data1D, reg_data2D (XLEN), stall (1), cannot_calcpc (1).

Function
REQ-011 SHALL hold E-tracking registers rdE_q (5) and wrE_q (1); on an accepted issue (issue & !stall & !flush) they load rdD and (reg_writeD & !is_loadD); otherwise rdE_q is held and wrE_q clears.
REQ-012 SHALL hold a 31-entry scoreboard (x1..x31); each entry has a down-counter cnt of clog2(LOAD_LAT+1) bits; the entry is busy while cnt != 0.
REQ-013 On an accepted issue with is_loadD & reg_writeD & rdD != 0, cnt[rdD] SHALL load LAT on the next edge; every other nonzero cnt SHALL decrement by 1 per cycle.
REQ-014 Simultaneous set and decrement of the same entry SHALL resolve as set (cnt = LOAD_LAT).
REQ-015 Register x0 SHALL never be busy, never match, and never be forwarded.
REQ-016 stall SHALL be 1 when rs1D or rs2D (nonzero) has cnt >= 2, or has cnt == 1 with no wb_valid & rdW match; combinational, same cycle.
REQ-017 For operand n, reg_datanD SHALL be selected by priority: aluE if rsnD == rdE_q & wrE_q; else resultW if wb_valid & rdW == rsnD; else sourcenD.
REQ-018 cannot_calcpc SHALL be 1 when jump_code == 01, or when jump_code == 11 and rs1D != 0 and (rs1D == rdE_q & wrE_q, or cnt[rs1D] != 0).
REQ-019 flush SHALL block scoreboard set and E-tracking load for the D instruction only; existing counters SHALL continue to count.
REQ-020 While stall = 1 the D instruction SHALL NOT be recorded, even if issue = 1.
REQ-021 wb_valid for a register with cnt >= 2 SHALL forward but SHALL NOT alter cnt.

Reset
REQ-022 rst_n low SHALL immediately clear all cnt, rdE_q and wrE_q, without waiting for clk.
REQ-023 During and after reset, stall = 0, and cannot_calcpc depends only on jump_code == 01.
REQ-024 During and after reset, reg_datanD = sourcenD unless a W match exists.
REQ-025 Reset mid-load SHALL discard the pending entry.

Configuration
REQ-026 With HAZ_STATS_EN defined, the block SHALL add outputs stall_cnt (32) and calc_cnt (32).
REQ-027 stall_cnt and calc_cnt SHALL count cycles with stall = 1 and cycles with cannot_calcpc = 1 respectively.
REQ-028 stall_cnt and calc_cnt SHALL saturate at 0xFFFFFFFF and clear on reset.
REQ-029 Without HAZ_STATS_EN, those ports and counters SHALL be absent, with identical other behaviour.

Verification (LOAD_LAT = 2)
REQ-030 Load x5 accepted at cycle t; at t+1, D reads rs1 = x5 -> stall = 1.
REQ-031 At t+2 with wb_valid, rdW = 5, resultW = 0xDEAD -> stall = 0 and reg_data1D = 0xDEAD.
REQ-032 ALU write x7 accepted; next cycle D reads rs2 = x7 with aluE = 0x1234 and a simultaneous W match on x7 carrying 0x5555 -> reg_data2D = 0x1234.
REQ-033 jalr with rs1 = x3 while cnt[x3] = 1 -> cannot_calcpc = 1.
REQ-034 jump_code = 01 -> cannot_calcpc = 1.
REQ-035 Load x0 issued -> no stall on a later rs1 = 0.
REQ-036 Load x9 issued with flush = 1 -> x9 never busy.
REQ-037 Load x4 accepted, then rst_n pulsed low between edges -> stall = 0 immediately, and x4 not busy afterwards.
REQ-038 HAZ_STATS_EN build, three stall cycles -> stall_cnt = 3.

Source files
------------

// File: rtl/d_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight loads per register, raises
// stall for load-use hazards, selects forwarded operands (E over W over RF) and
// flags when a branch/jalr target cannot be computed in D.
// Optional build macro HAZ_STATS_EN adds saturating stall/cannot_calcpc counters.
module d_hazard_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LOAD_LAT = 2    // legal 1..7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue,
  input  logic            flush,
  input  logic [4:0]      rs1D,
  input  logic [4:0]      rs2D,
  input  logic [4:0]      rdD,
  input  logic            reg_writeD,
  input  logic            is_loadD,
  input  logic [1:0]      jump_code,
  input  logic [XLEN-1:0] source1D,
  input  logic [XLEN-1:0] source2D,
  input  logic [XLEN-1:0] aluE,
  input  logic            wb_valid,
  input  logic [4:0]      rdW,
  input  logic [XLEN-1:0] resultW,
  output logic [XLEN-1:0] reg_data1D,
  output logic [XLEN-1:0] reg_data2D,
  output logic            stall,
  output logic            cannot_calcpc
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     calc_cnt
`endif
);

  localparam int unsigned CntW = $clog2(LOAD_LAT + 1);
  localparam logic [CntW-1:0] LatVal = CntW'(LOAD_LAT);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // Entry 0 exists only so x0 can be indexed directly; it is held at zero.
  logic [CntW-1:0] cnt_q [32];
  logic [CntW-1:0] cnt_d [32];
  logic [4:0]      rdE_q, rdE_d;
  logic            wrE_q, wrE_d;

  logic            accept;
  logic            load_set;
  logic [CntW-1:0] cnt1, cnt2;
  logic            e_hit1, e_hit2;
  logic            w_hit1, w_hit2;
  logic            stall1, stall2;

  // Per-operand match and load-use hazard detection.
  always_comb begin
    cnt1   = cnt_q[rs1D];
    cnt2   = cnt_q[rs2D];
    e_hit1 = (rs1D != 5'd0) && wrE_q && (rdE_q == rs1D);
    e_hit2 = (rs2D != 5'd0) && wrE_q && (rdE_q == rs2D);
    w_hit1 = (rs1D != 5'd0) && wb_valid && (rdW == rs1D);
    w_hit2 = (rs2D != 5'd0) && wb_valid && (rdW == rs2D);
    // cnt == 1 means the data lands on resultW this cycle; only then can W cover it.
    stall1 = (rs1D != 5'd0) && ((cnt1 > CntOne) || ((cnt1 == CntOne) && !w_hit1));
    stall2 = (rs2D != 5'd0) && ((cnt2 > CntOne) || ((cnt2 == CntOne) && !w_hit2));
  end

  // Outputs: stall, operand forwarding mux and jump-target availability.
  always_comb begin
    stall = stall1 || stall2;

    if (e_hit1)      reg_data1D = aluE;
    else if (w_hit1) reg_data1D = resultW;
    else             reg_data1D = source1D;

    if (e_hit2)      reg_data2D = aluE;
    else if (w_hit2) reg_data2D = resultW;
    else             reg_data2D = source2D;

    cannot_calcpc = 1'b0;
    if (jump_code == 2'b01) begin
      cannot_calcpc = 1'b1;
    end else if (jump_code == 2'b11 && rs1D != 5'd0) begin
      cannot_calcpc = e_hit1 || (cnt1 != '0);
    end
  end

  // Next state for E tracking and the per-register load countdowns.
  always_comb begin
    accept   = issue && !stall && !flush;
    load_set = accept && is_loadD && reg_writeD && (rdD != 5'd0);
    rdE_d    = accept ? rdD : rdE_q;
    wrE_d    = accept && reg_writeD && !is_loadD;
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CntOne;
      // A new load to the same register overrides the decrement.
      if (load_set && (rdD == 5'(i))) cnt_d[i] = LatVal;
    end
    cnt_d[0] = '0;
  end

  // State registers, cleared asynchronously so a reset drops pending loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdE_q <= 5'd0;
      wrE_q <= 1'b0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      rdE_q <= rdE_d;
      wrE_q <= wrE_d;
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] calc_cnt_q, calc_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    calc_cnt_d  = calc_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF)        stall_cnt_d = stall_cnt_q + 32'd1;
    if (cannot_calcpc && calc_cnt_q != 32'hFFFF_FFFF) calc_cnt_d  = calc_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      calc_cnt_q  <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      calc_cnt_q  <= calc_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign calc_cnt  = calc_cnt_q;
`endif

endmodule

// File: tb/tb_d_hazard_scoreboard.sv
// Bench for d_hazard_scoreboard (XLEN = 32, LOAD_LAT = 2). Expected outputs are
// queued as each cycle's stimulus is applied and compared when sampled.
module tb_d_hazard_scoreboard;

  localparam logic [31:0] S1  = 32'hA1A1_A1A1;
  localparam logic [31:0] S2  = 32'hB2B2_B2B2;
  localparam logic [31:0] ALU = 32'h7777_7777;

  logic        clk, rst_n, issue, flush;
  logic [4:0]  rs1D, rs2D, rdD, rdW;
  logic        reg_writeD, is_loadD, wb_valid;
  logic [1:0]  jump_code;
  logic [31:0] source1D, source2D, aluE, resultW;
  logic [31:0] reg_data1D, reg_data2D;
  logic        stall, cannot_calcpc;
`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt, calc_cnt;
`endif

  d_hazard_scoreboard #(
    .XLEN     (32),
    .LOAD_LAT (2)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue         (issue),
    .flush         (flush),
    .rs1D          (rs1D),
    .rs2D          (rs2D),
    .rdD           (rdD),
    .reg_writeD    (reg_writeD),
    .is_loadD      (is_loadD),
    .jump_code     (jump_code),
    .source1D      (source1D),
    .source2D      (source2D),
    .aluE          (aluE),
    .wb_valid      (wb_valid),
    .rdW           (rdW),
    .resultW       (resultW),
    .reg_data1D    (reg_data1D),
    .reg_data2D    (reg_data2D),
    .stall         (stall),
    .cannot_calcpc (cannot_calcpc)
`ifdef HAZ_STATS_EN
    ,
    .stall_cnt     (stall_cnt),
    .calc_cnt      (calc_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        st;
    logic        cc;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic set_idle();
    issue = 1'b0; flush = 1'b0; rs1D = 5'd0; rs2D = 5'd0; rdD = 5'd0;
    reg_writeD = 1'b0; is_loadD = 1'b0; jump_code = 2'b00;
    source1D = S1; source2D = S2; aluE = ALU;
    wb_valid = 1'b0; rdW = 5'd0; resultW = 32'h5A5A_5A5A;
  endtask

  // Inputs change on the falling edge, well away from the rising edge.
  task automatic next_cycle();
    @(negedge clk);
    set_idle();
  endtask

  task automatic sample_out();
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({e.tag, ".stall"}, 32'(stall), 32'(e.st));
      check_eq({e.tag, ".calc"}, 32'(cannot_calcpc), 32'(e.cc));
      check_eq({e.tag, ".d1"}, reg_data1D, e.d1);
      check_eq({e.tag, ".d2"}, reg_data2D, e.d2);
    end
  endtask

  task automatic expect_out(input string tag, input logic st, input logic cc,
                            input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    e.tag = tag; e.st = st; e.cc = cc; e.d1 = d1; e.d2 = d2;
    exp_q.push_back(e);
    sample_out();
  endtask

  task automatic issue_load(input logic [4:0] rd);
    issue = 1'b1; is_loadD = 1'b1; reg_writeD = 1'b1; rdD = rd;
  endtask

  task automatic issue_alu(input logic [4:0] rd);
    issue = 1'b1; is_loadD = 1'b0; reg_writeD = 1'b1; rdD = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    rs1D = 5'd5; rs2D = 5'd7;
    #2 expect_out("rst_idle", 0, 0, S1, S2);
    jump_code = 2'b01; wb_valid = 1'b1; rdW = 5'd5; resultW = 32'hDEAD;
    expect_out("rst_wfwd", 0, 1, 32'hDEAD, S2);
    jump_code = 2'b11; wb_valid = 1'b0;
    expect_out("rst_jalr", 0, 0, S1, S2);
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;

    // Load-use stall, then W forwarding; a stalled ALU op must not be recorded.
    next_cycle(); issue_load(5'd5);
    expect_out("ld5_issue", 0, 0, S1, S2);
    next_cycle(); issue_alu(5'd6); rs1D = 5'd5;
    expect_out("ld5_stall", 1, 0, S1, S2);
    next_cycle(); rs1D = 5'd5; rs2D = 5'd6; wb_valid = 1'b1; rdW = 5'd5; resultW = 32'hDEAD;
    expect_out("ld5_wb", 0, 0, 32'hDEAD, S2);
    next_cycle(); rs1D = 5'd5;
    expect_out("ld5_done", 0, 0, S1, S2);

    // E beats W; once E is gone W forwards.
    next_cycle(); issue_alu(5'd7);
    expect_out("alu7_issue", 0, 0, S1, S2);
    next_cycle(); rs2D = 5'd7; aluE = 32'h1234; wb_valid = 1'b1; rdW = 5'd7; resultW = 32'h5555;
    expect_out("alu7_fwd", 0, 0, S1, 32'h1234);
    next_cycle(); rs2D = 5'd7; wb_valid = 1'b1; rdW = 5'd7; resultW = 32'h5555;
    expect_out("w7_fwd", 0, 0, S1, 32'h5555);

    // jalr against a pending load and against an E-stage writer.
    next_cycle(); issue_load(5'd3);
    expect_out("ld3_issue", 0, 0, S1, S2);
    next_cycle(); jump_code = 2'b11; rs1D = 5'd3;
    expect_out("jalr3_c2", 1, 1, S1, S2);
    next_cycle(); jump_code = 2'b11; rs1D = 5'd3;
    expect_out("jalr3_c1", 1, 1, S1, S2);
    next_cycle(); jump_code = 2'b11; rs1D = 5'd3;
    expect_out("jalr3_free", 0, 0, S1, S2);
    next_cycle(); issue_alu(5'd3);
    expect_out("alu3_issue", 0, 0, S1, S2);
    next_cycle(); jump_code = 2'b11; rs1D = 5'd3;
    expect_out("jalr3_e", 0, 1, ALU, S2);
    next_cycle(); jump_code = 2'b01;
    expect_out("branch", 0, 1, S1, S2);

    // x0 is never busy and never forwarded.
    next_cycle(); issue_load(5'd0);
    expect_out("ld0_issue", 0, 0, S1, S2);
    next_cycle(); wb_valid = 1'b1; rdW = 5'd0; resultW = 32'hBAD0;
    expect_out("x0_rd", 0, 0, S1, S2);
    next_cycle(); issue_alu(5'd0);
    expect_out("alu0_issue", 0, 0, S1, S2);
    next_cycle(); jump_code = 2'b11;
    expect_out("x0_nofwd", 0, 0, S1, S2);

    // Flushed instructions leave no trace.
    next_cycle(); issue_load(5'd9); flush = 1'b1;
    expect_out("ld9_flush", 0, 0, S1, S2);
    next_cycle(); rs1D = 5'd9;
    expect_out("flush9_a", 0, 0, S1, S2);
    next_cycle(); rs1D = 5'd9;
    expect_out("flush9_b", 0, 0, S1, S2);
    next_cycle(); issue_alu(5'd10); flush = 1'b1;
    expect_out("alu10_flush", 0, 0, S1, S2);
    next_cycle(); rs1D = 5'd10;
    expect_out("flush10", 0, 0, S1, S2);

    // Re-load of x5 while its countdown expires: set wins over decrement.
    next_cycle(); issue_load(5'd5);
    expect_out("re5_issue", 0, 0, S1, S2);
    next_cycle(); rs1D = 5'd5;
    expect_out("re5_c2", 1, 0, S1, S2);
    next_cycle(); issue_load(5'd5); rs1D = 5'd5; wb_valid = 1'b1; rdW = 5'd5; resultW = 32'hDEAD;
    expect_out("re5_set", 0, 0, 32'hDEAD, S2);
    next_cycle(); rs1D = 5'd5;
    expect_out("re5_c2b", 1, 0, S1, S2);
    next_cycle(); rs1D = 5'd5;
    expect_out("re5_c1b", 1, 0, S1, S2);
    next_cycle(); rs1D = 5'd5;
    expect_out("re5_free", 0, 0, S1, S2);

    // Early W match forwards but does not shorten the countdown.
    next_cycle(); issue_load(5'd8);
    expect_out("ld8_issue", 0, 0, S1, S2);
    next_cycle(); rs1D = 5'd8; wb_valid = 1'b1; rdW = 5'd8; resultW = 32'hCAFE;
    expect_out("wb8_early", 1, 0, 32'hCAFE, S2);
    next_cycle(); rs1D = 5'd8;
    expect_out("wb8_kept", 1, 0, S1, S2);
    next_cycle(); rs1D = 5'd8;
    expect_out("wb8_free", 0, 0, S1, S2);

    // Asynchronous reset between edges drops a pending load.
    next_cycle(); issue_load(5'd4);
    expect_out("ld4_issue", 0, 0, S1, S2);
    next_cycle(); rs1D = 5'd4; rs2D = 5'd4; jump_code = 2'b11;
    expect_out("ld4_busy", 1, 1, S1, S2);
    rst_n = 1'b0;
    expect_out("ld4_rst", 0, 0, S1, S2);
    rst_n = 1'b1;
    next_cycle(); rs1D = 5'd4;
    expect_out("ld4_gone", 0, 0, S1, S2);
`ifdef HAZ_STATS_EN
    check_eq("stall_cnt_rst", stall_cnt, 32'd0);
    check_eq("calc_cnt_rst", calc_cnt, 32'd0);
`endif

    // Three stall cycles in total.
    next_cycle(); issue_load(5'd5);
    expect_out("st_ld5", 0, 0, S1, S2);
    next_cycle(); rs1D = 5'd5;
    expect_out("st_a", 1, 0, S1, S2);
    next_cycle(); rs1D = 5'd5;
    expect_out("st_b", 1, 0, S1, S2);
    next_cycle(); issue_load(5'd6);
    expect_out("st_ld6", 0, 0, S1, S2);
    next_cycle(); rs2D = 5'd6;
    expect_out("st_c", 1, 0, S1, S2);
    next_cycle(); jump_code = 2'b01;
    expect_out("st_branch", 0, 1, S1, S2);
    next_cycle();
    expect_out("st_end", 0, 0, S1, S2);
`ifdef HAZ_STATS_EN
    check_eq("stall_cnt", stall_cnt, 32'd3);
    check_eq("calc_cnt", calc_cnt, 32'd1);
`endif

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
